// File: rtl/pcie_tlp_pkg.sv
// Shared TLP field constants, header layouts and helpers for the endpoint's
// requester and completer paths.
package pcie_tlp_pkg;

    localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;

    localparam logic [7:0] TREM_N_BOTH    = 8'h00;
    localparam logic [7:0] TREM_N_UPPER   = 8'h0F;

    typedef struct packed {
        logic [7:0] bus;
        logic [4:0] dev;
        logic [2:0] fn;
    } req_id_t;

    typedef struct packed {
        logic       rsvd0;
        logic [1:0] fmt;
        logic [4:0] typ;
        logic       rsvd1;
        logic [2:0] tc;
        logic [3:0] rsvd2;
        logic       td;
        logic       ep;
        logic [1:0] attr;
        logic [1:0] rsvd3;
        logic [9:0] length;
    } tlp_hdr_dw0_t;

    typedef struct packed {
        req_id_t    req_id;
        logic [7:0] tag;
        logic [3:0] last_be;
        logic [3:0] first_be;
    } tlp_req_dw1_t;

    function automatic req_id_t pack_req_id(input logic [7:0] bus,
                                            input logic [4:0] dev,
                                            input logic [2:0] fn);
        req_id_t rid;
        rid.bus = bus;
        rid.dev = dev;
        rid.fn  = fn;
        return rid;
    endfunction

    // Host memory is little-endian; the TRN link carries DWs big-endian.
    function automatic logic [31:0] SwapDWB(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [63:0] mwr_hdr(input logic [9:0] len,
                                            input req_id_t    rid,
                                            input logic [7:0] tag);
        tlp_hdr_dw0_t h0;
        tlp_req_dw1_t h1;
        h0          = '0;
        h0.fmt      = FMT_3DW_DATA;
        h0.typ      = TYPE_MEM;
        h0.length   = len;
        h1.req_id   = rid;
        h1.tag      = tag;
        h1.last_be  = (len == 10'd1) ? 4'h0 : 4'hF;
        h1.first_be = 4'hF;
        return {h0, h1};
    endfunction

endpackage

// File: rtl/dw_buffer.sv
// Payload staging RAM: one synchronous write port, two asynchronous read
// ports so a 64-bit beat can be assembled from two consecutive DWs.
module dw_buffer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [31:0]   rdata_a,
    output logic [31:0]   rdata_b
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dma_wr_requester.sv
// Bus-master write requester: buffers a burst from a local stream and emits a
// single 3DW-header MemWr TLP on the 64-bit TRN transmit link.
module dma_wr_requester
    import pcie_tlp_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_DW = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic [9:0]  start_len,
    input  logic        bus_master_en,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [7:0]  cfg_bus_number,
    input  logic [4:0]  cfg_device_number,
    input  logic [2:0]  cfg_function_number,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n
);

    localparam int unsigned AW = $clog2(MAX_PAYLOAD_DW);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_HDR,
        ST_ADDR,
        ST_DATA
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [9:0]  len_q, len_d;
    req_id_t     req_id_q, req_id_d;
    logic [7:0]  tag_q, tag_d;
    logic [9:0]  wr_idx_q, wr_idx_d;
    logic [9:0]  rd_idx_q, rd_idx_d;
    logic        wr_ready_q, wr_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [63:0] td_q, td_d;
    logic [7:0]  trem_n_q, trem_n_d;
    logic        tsof_n_q, tsof_n_d;
    logic        teof_n_q, teof_n_d;
    logic        tsrc_rdy_n_q, tsrc_rdy_n_d;

    logic [31:0] rd_data_a, rd_data_b;
    logic [10:0] end_dw_c;
    logic        bad_req_c;
    logic        wr_fire_c;
    logic        beat_xfer_c;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^start_addr[1:0];

    // 4 KB crossing check in DW units: end offset may reach but not pass 1024.
    assign end_dw_c  = 11'(start_addr[11:2]) + 11'(start_len);
    assign bad_req_c = (start_len == 10'd0) || (start_len > 10'(MAX_PAYLOAD_DW)) ||
                       !bus_master_en || (end_dw_c > 11'd1024);

    assign wr_fire_c   = (state_q == ST_FILL) && wr_valid && wr_ready_q;
    assign beat_xfer_c = !tsrc_rdy_n_q && !trn_tdst_rdy_n;

    dw_buffer #(
        .DEPTH (MAX_PAYLOAD_DW),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we      (wr_fire_c),
        .waddr   (AW'(wr_idx_q)),
        .wdata   (wr_data),
        .raddr_a (AW'(rd_idx_q)),
        .raddr_b (AW'(rd_idx_q + 10'd1)),
        .rdata_a (rd_data_a),
        .rdata_b (rd_data_b)
    );

    // Next-state and next-beat logic; the following beat is loaded on the
    // edge that accepts the current one so beats stay back-to-back.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        req_id_d     = req_id_q;
        tag_d        = tag_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        wr_ready_d   = wr_ready_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        td_d         = td_q;
        trem_n_d     = trem_n_q;
        tsof_n_d     = tsof_n_q;
        teof_n_d     = teof_n_q;
        tsrc_rdy_n_d = tsrc_rdy_n_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (bad_req_c) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d     = start_addr[31:2];
                        len_d      = start_len;
                        req_id_d   = pack_req_id(cfg_bus_number, cfg_device_number,
                                                 cfg_function_number);
                        wr_idx_d   = 10'd0;
                        wr_ready_d = 1'b1;
                        state_d    = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (wr_fire_c) begin
                    wr_idx_d = wr_idx_q + 10'd1;
                    if (wr_idx_q == len_q - 10'd1) begin
                        wr_ready_d   = 1'b0;
                        rd_idx_d     = 10'd0;
                        td_d         = mwr_hdr(len_q, req_id_q, tag_q);
                        tsof_n_d     = 1'b0;
                        teof_n_d     = 1'b1;
                        trem_n_d     = TREM_N_BOTH;
                        tsrc_rdy_n_d = 1'b0;
                        state_d      = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (beat_xfer_c) begin
                    tsof_n_d = 1'b1;
                    td_d     = {addr_q, 2'b00, SwapDWB(rd_data_a)};
                    rd_idx_d = 10'd1;
                    if (len_q == 10'd1) begin
                        teof_n_d = 1'b0;
                        trem_n_d = TREM_N_BOTH;
                    end
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (beat_xfer_c) begin
                    if (!teof_n_q) begin
                        tag_d        = tag_q + 8'd1;
                        done_d       = 1'b1;
                        td_d         = 64'd0;
                        trem_n_d     = TREM_N_BOTH;
                        teof_n_d     = 1'b1;
                        tsrc_rdy_n_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        td_d[63:32] = SwapDWB(rd_data_a);
                        td_d[31:0]  = (rd_idx_q + 10'd1 < len_q) ? SwapDWB(rd_data_b) : 32'd0;
                        rd_idx_d    = rd_idx_q + 10'd2;
                        if (rd_idx_q + 10'd2 >= len_q) begin
                            teof_n_d = 1'b0;
                            trem_n_d = len_q[0] ? TREM_N_BOTH : TREM_N_UPPER;
                        end
                        state_d = ST_DATA;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            req_id_q     <= '0;
            tag_q        <= '0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            wr_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            td_q         <= '0;
            trem_n_q     <= TREM_N_BOTH;
            tsof_n_q     <= 1'b1;
            teof_n_q     <= 1'b1;
            tsrc_rdy_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            req_id_q     <= req_id_d;
            tag_q        <= tag_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            wr_ready_q   <= wr_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            td_q         <= td_d;
            trem_n_q     <= trem_n_d;
            tsof_n_q     <= tsof_n_d;
            teof_n_q     <= teof_n_d;
            tsrc_rdy_n_q <= tsrc_rdy_n_d;
        end
    end

    assign wr_ready       = wr_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign trn_td         = td_q;
    assign trn_trem_n     = trem_n_q;
    assign trn_tsof_n     = tsof_n_q;
    assign trn_teof_n     = teof_n_q;
    assign trn_tsrc_rdy_n = tsrc_rdy_n_q;

endmodule

// File: tb/tb_dma_wr_requester.sv
// Directed + randomized bench for dma_wr_requester; expected TLPs are built
// from a flat DW list (header, address, swapped payload, pad) split into beats.
module tb_dma_wr_requester;

    localparam int unsigned MAXP = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_addr;
    logic [9:0]  start_len;
    logic        bus_master_en;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  cfg_bus_number;
    logic [4:0]  cfg_device_number;
    logic [2:0]  cfg_function_number;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_tag = 8'd0;
    logic [31:0] pay [256];
    logic [63:0] cap [256];
    int          ncap;
    logic [7:0]  last_trem;

    always #8 clk = ~clk;

    dma_wr_requester #(.MAX_PAYLOAD_DW(MAXP)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .start_addr          (start_addr),
        .start_len           (start_len),
        .bus_master_en       (bus_master_en),
        .wr_data             (wr_data),
        .wr_valid            (wr_valid),
        .wr_ready            (wr_ready),
        .busy                (busy),
        .done                (done),
        .err                 (err),
        .cfg_bus_number      (cfg_bus_number),
        .cfg_device_number   (cfg_device_number),
        .cfg_function_number (cfg_function_number),
        .trn_td              (trn_td),
        .trn_trem_n          (trn_trem_n),
        .trn_tsof_n          (trn_tsof_n),
        .trn_teof_n          (trn_teof_n),
        .trn_tsrc_rdy_n      (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n      (trn_tdst_rdy_n)
    );

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {<<8{x}};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_td"}, trn_td, 64'd0);
        check({pfx, "_trem"}, trn_trem_n, 8'h00);
        check({pfx, "_sof"}, trn_tsof_n, 1'b1);
        check({pfx, "_eof"}, trn_teof_n, 1'b1);
        check({pfx, "_src"}, trn_tsrc_rdy_n, 1'b1);
        check({pfx, "_wrrdy"}, wr_ready, 1'b0);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_done"}, done, 1'b0);
        check({pfx, "_err"}, err, 1'b0);
    endtask

    task automatic fill_pay(input int len);
        for (int i = 0; i < len; i++) pay[i] = $urandom;
    endtask

    task automatic reject(input string tag, input logic [31:0] addr, input int len,
                          input logic bme);
        start = 1'b1; start_addr = addr; start_len = 10'(len); bus_master_en = bme;
        @(negedge clk);
        start = 1'b0; bus_master_en = 1'b1;
        check({tag, "_err"}, err, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_src"}, trn_tsrc_rdy_n, 1'b1);
        @(negedge clk);
        check({tag, "_errclr"}, err, 1'b0);
        check({tag, "_busy2"}, busy, 1'b0);
        check({tag, "_src2"}, trn_tsrc_rdy_n, 1'b1);
    endtask

    // Called at a negedge; returns at the negedge where done should be high
    // (or right after the mid-packet reset when rst_beat >= 0).
    task automatic run_tlp(input logic [31:0] addr, input int len, input logic [15:0] rid,
                           input int bp_mode, input bit gappy, input int rst_beat);
        logic [31:0] dws [$];
        logic [63:0] eb [$];
        logic [63:0] snap;
        bit          pad, prev_hold, fin, aborted;
        int          idx, got, src_gaps, hold_errs, err_seen, nbeats;

        dws = {};
        dws.push_back(32'h4000_0000 | 32'(len));
        dws.push_back({rid, exp_tag, (len == 1) ? 4'h0 : 4'hF, 4'hF});
        dws.push_back({addr[31:2], 2'b00});
        for (int i = 0; i < len; i++) dws.push_back(bswap(pay[i]));
        pad = (dws.size() % 2) != 0;
        if (pad) dws.push_back(32'd0);
        eb = {};
        for (int i = 0; i < dws.size() / 2; i++) eb.push_back({dws[2*i], dws[2*i+1]});
        nbeats = eb.size();

        start = 1'b1; start_addr = addr; start_len = 10'(len); bus_master_en = 1'b1;
        {cfg_bus_number, cfg_device_number, cfg_function_number} = rid;
        @(negedge clk);
        start = 1'b0;
        {cfg_bus_number, cfg_device_number, cfg_function_number} = 16'($urandom);
        check("prev_done_low", done, 1'b0);
        check("fill_ready", wr_ready, 1'b1);
        check("fill_busy", busy, 1'b1);

        idx = 0; err_seen = 0;
        for (int c = 0; c < 4000 && idx < len; c++) begin
            if (err) err_seen++;
            wr_valid = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
            wr_data  = wr_valid ? pay[idx] : $urandom;
            start     = ($urandom_range(0, 3) == 0);
            start_len = 10'd0;
            if (wr_valid && wr_ready) idx++;
            @(negedge clk);
        end
        wr_valid = 1'b0; start = 1'b0;
        check("fill_count", idx, len);
        check("busy_start_ignored", err_seen, 0);
        check("launch_src", trn_tsrc_rdy_n, 1'b0);
        check("fill_ready_low", wr_ready, 1'b0);

        got = 0; src_gaps = 0; hold_errs = 0; prev_hold = 1'b0;
        fin = 1'b0; aborted = 1'b0; snap = '0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            if (rst_beat >= 0 && got == rst_beat) begin
                rst = 1'b1; trn_tdst_rdy_n = 1'b1;
                @(negedge clk);
                check_reset("midrst");
                rst = 1'b0; exp_tag = 8'd0; aborted = 1'b1;
                break;
            end
            if (trn_tsrc_rdy_n !== 1'b0) src_gaps++;
            if (prev_hold && {trn_td[63:8], trn_trem_n, trn_tsof_n, trn_teof_n}
                             !== {snap[63:8], last_trem, snap[1:0]}) hold_errs++;
            case (bp_mode)
                0:       trn_tdst_rdy_n = 1'b0;
                1:       trn_tdst_rdy_n = (c % 2 == 0);
                default: trn_tdst_rdy_n = $urandom_range(0, 1) != 0;
            endcase
            snap = {trn_td[63:8], 6'd0, trn_tsof_n, trn_teof_n};
            last_trem = trn_trem_n;
            prev_hold = trn_tdst_rdy_n;
            if (!trn_tdst_rdy_n && !trn_tsrc_rdy_n) begin
                cap[got % 256] = trn_td;
                check("beat_td", trn_td, (got < nbeats) ? eb[got] : 64'hDEAD);
                check("beat_sof", trn_tsof_n, (got == 0) ? 1'b0 : 1'b1);
                check("beat_eof", trn_teof_n, (got == nbeats - 1) ? 1'b0 : 1'b1);
                if (got == nbeats - 1) check("last_trem", trn_trem_n, pad ? 8'h0F : 8'h00);
                got++;
                if (!trn_teof_n) fin = 1'b1;
            end
            @(negedge clk);
        end
        ncap = got;
        if (aborted) return;
        trn_tdst_rdy_n = 1'b1;
        check("tx_finished", fin, 1'b1);
        check("beat_count", got, nbeats);
        check("src_gaps", src_gaps, 0);
        check("hold_while_busy", hold_errs, 0);
        check("done_pulse", done, 1'b1);
        check("idle_at_done", busy, 1'b0);
        check("src_released", trn_tsrc_rdy_n, 1'b1);
        exp_tag = exp_tag + 8'd1;
    endtask

    task automatic random_run();
        int          len, dwoff;
        logic [31:0] r;
        len   = $urandom_range(1, MAXP);
        dwoff = $urandom_range(0, 1024 - len);
        r     = $urandom;
        fill_pay(len);
        run_tlp({r[31:12], 10'(dwoff), r[1:0]}, len, 16'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 1) != 0, -1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; start_len = '0; bus_master_en = 1'b1;
        wr_data = '0; wr_valid = 1'b0; trn_tdst_rdy_n = 1'b1;
        cfg_bus_number = '0; cfg_device_number = '0; cfg_function_number = '0;
        ncap = 0; last_trem = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        pay[0] = 32'h1122_3344;
        run_tlp(32'h0000_1000, 1, 16'h0100, 0, 1'b0, -1);
        check("t1_hdr", cap[0], 64'h4000_0001_0100_000F);
        check("t1_addr", cap[1], 64'h0000_1000_4433_2211);
        check("t1_trem", last_trem, 8'h00);
        @(negedge clk);
        check("t1_done_once", done, 1'b0);

        fill_pay(2);
        run_tlp(32'h2000_0040, 2, 16'h0100, 1, 1'b0, -1);
        check("t2_last", cap[2], {bswap(pay[1]), 32'd0});
        check("t2_trem", last_trem, 8'h0F);
        check("t2_lastbe", cap[0][7:4], 4'hF);
        check("t2_tag", cap[0][15:8], 8'h01);

        fill_pay(32);
        run_tlp(32'h8000_0F80, 32, 16'($urandom), 0, 1'b1, -1);
        check("t3_beats", ncap, 18);

        pay[0] = $urandom;
        run_tlp(32'h1234_5FFE, 1, 16'hABCD, 2, 1'b0, -1);

        reject("rej_len0", 32'h0000_1000, 0, 1'b1);
        reject("rej_len33", 32'h0000_1000, 33, 1'b1);
        reject("rej_bme", 32'h0000_1000, 4, 1'b0);
        reject("rej_4k", 32'h0000_0FFC, 2, 1'b1);

        fill_pay(8);
        run_tlp(32'h0000_3000, 8, 16'h0208, 0, 1'b0, 2);
        fill_pay(3);
        run_tlp(32'h0000_4000, 3, 16'h0308, 0, 1'b0, -1);
        check("tag_after_rst", cap[0][15:8], 8'h00);

        for (int i = 0; i < 255; i++) random_run();
        random_run();
        check("tag_wrap", cap[0][15:8], 8'h00);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dma_wr_requester.md
# dma_wr_requester

Bus-master write requester for the PCIe endpoint's 64-bit TRN transmit local-link. It collects a burst of up to `MAX_PAYLOAD_DW` 32-bit words from a local streaming source. It then emits one 3DW-header Memory Write TLP (posted) addressed to host memory. It is the initiator-side counterpart of the endpoint's target logic, which receives MemRd/MemWr TLPs and answers completions. It shares the TX link with that completion path through an external arbiter, driven by `busy`.

## Interface
- `MAX_PAYLOAD_DW`, 32: maximum payload in DWs (128 bytes). Must be an even number, 2..256.
- `clk` in 1: `trn_clk` domain, 62.5 MHz.
- `rst` in 1: synchronous, active-high. Only clock; all logic in `clk`.
- `start` in 1: one-cycle request. Ignored unless in IDLE.
- `start_addr` in 32: host byte address. Bits [1:0] are ignored and treated as 0.
- `start_len` in 10: payload length in DWs.
- `bus_master_en` in 1: Command register bit 2.
- `wr_data` in 32: payload word.
- `wr_valid` in 1: payload word available.
- `wr_ready` out 1: word accepted on `wr_valid & wr_ready`.
- `busy` out 1: block is not in IDLE.
- `done` out 1: one-cycle pulse when the TLP's EOF beat is accepted.
- `err` out 1: one-cycle pulse when a request is rejected.
- `cfg_bus_number` in 8: requester ID, bus field.
- `cfg_device_number` in 5: requester ID, device field.
- `cfg_function_number` in 3: requester ID, function field.
- `trn_td` out 64: TX data.
- `trn_trem_n` out 8: TX remainder. 8'h00 means both DWs valid; 8'h0F means only [63:32] valid.
- `trn_tsof_n` out 1: TX start of frame, active-low.
- `trn_teof_n` out 1: TX end of frame, active-low.
- `trn_tsrc_rdy_n` out 1: TX source ready, active-low.
- `trn_tdst_rdy_n` in 1: TX destination ready, active-low. A beat transfers when both ready signals are low.

## Operation
- **States:** IDLE → FILL → HDR → ADDR → DATA → IDLE. The DATA state is skipped when `start_len`==1.
- **Request validation in IDLE:** `start` is rejected, with `err` pulsed on the next cycle and the state staying IDLE, if any of the following holds:
  - `start_len`==0;
  - `start_len` > `MAX_PAYLOAD_DW`;
  - `bus_master_en`==0;
  - the request crosses a 4 KB boundary, i.e. `start_addr[11:2] + start_len` > 1024.
- **Accepted request:** latch the address, length and requester ID, then go to FILL.
- **FILL:** `wr_ready`=1. Words are written into the buffer in order. After the `start_len`-th word is accepted, `wr_ready` drops and the state moves to HDR. `wr_ready` is 0 in every other state.
- **HDR beat:**
  - `trn_td[63:32]` = {1'b0, fmt 2'b10, type 5'b00000, 1'b0, TC 3'b0, 4'b0, TD 0, EP 0, attr 2'b0, 2'b0, length}.
  - `trn_td[31:0]` = {requester ID (bus, dev, fn), tag, lastBE, firstBE 4'hF}.
  - lastBE is 4'h0 when length==1, otherwise 4'hF.
  - `trn_tsof_n`=0.
- **ADDR beat:** `trn_td` = {addr[31:2], 2'b00, swap(DW0)}.
- **DATA beats:** beat k ≥ 3 carries {swap(DW[2k-5]), swap(DW[2k-4])}. Beats total ceil((3+len)/2).
- **Last beat:**
  - `trn_teof_n`=0.
  - `trn_trem_n`=8'h0F when len is even (upper DW only; lower DW driven 0), else 8'h00.
  - For len==1 the ADDR beat is the last beat.
- **Byte swap:** swap(x) = {x[7:0], x[15:8], x[23:16], x[31:24]}, applied to every payload DW.
- **Tag:** 8-bit counter, reset value 0, increments on each `done` and wraps 255→0.

## Timing
- **Reset values:** `trn_tsrc_rdy_n`=1, `trn_tsof_n`=1, `trn_teof_n`=1, `trn_trem_n`=8'h00, `trn_td`=0, `wr_ready`=0, `busy`=0, `done`=0, `err`=0, tag=0, state IDLE.
- **All TX outputs are registered.**
- **Launch latency:**
  - `trn_tsrc_rdy_n` falls the cycle after the last FILL word is accepted.
  - It then stays low continuously until the EOF beat is accepted; there are no source bubbles mid-packet.
- **Backpressure:** while `trn_tdst_rdy_n`=1, `trn_td`, `trn_trem_n`, `trn_tsof_n` and `trn_teof_n` hold their values.
- **End of packet:**
  - `done` pulses in the cycle after EOF is accepted.
  - The block is back in IDLE in that same cycle.
  - A new `start` is accepted from that cycle onward.
- **Minimum turnaround:** `start` → FILL takes 1 cycle; FILL lasts ≥ len cycles.
- **`start` while busy:** ignored; no `err`.
- **`rst` mid-packet:** the block returns to IDLE immediately and the TLP is abandoned. Link recovery is the top level's responsibility.

## Structure
- **Package `pcie_tlp_pkg`:**
  - fmt/type constants (`FMT_3DW_DATA`, `TYPE_MEM`, `FMT_3DW_NODATA`, `TYPE_CPL`);
  - the requester-ID packing function;
  - the `SwapDWB` byte-swap function;
  - `trem_n` constants.
  - The existing completion path is refactored to use the same package.
- **Sub-module `dw_buffer`:** simple dual-port, `MAX_PAYLOAD_DW`×32 distributed RAM with a synchronous write and an asynchronous read. The read index is prefetched one beat ahead so beats stay back-to-back.

## Test plan
- **len=1, basic write:** addr 0x0000_1000, bus/dev/fn 1/0/0, data 0x11223344, `trn_tdst_rdy_n`=0.
  - Beat 1 = 0x4000_0001_0100_000F, SOF.
  - Beat 2 = 0x0000_1000_4433_2211, EOF, `trn_trem_n`=8'h00.
  - `done` 1 cycle later.
- **len=2 with backpressure:** addr 0x2000_0040, `trn_tdst_rdy_n` toggled 1/0 every cycle.
  - Three beats; the last is {swap(DW1), 32'h0}, `trn_trem_n`=8'h0F.
  - Outputs hold while not ready.
  - lastBE = F; tag = 1 on the second TLP.
- **len=`MAX_PAYLOAD_DW`=32 with a gappy source:** `wr_valid` randomly gapped.
  - 18 beats.
  - No `trn_tsrc_rdy_n` gaps after SOF.
  - Payload order and swap verified against a scoreboard.
- **Rejections:**
  - len=0 → `err`;
  - len=33 → `err`;
  - `bus_master_en`=0 → `err`;
  - addr 0x0000_0FFC with len=2 → `err`.
  - In every case `trn_tsrc_rdy_n` stays 1 and `busy` stays 0.
- **Reset and tag wrap:**
  - `rst` asserted on the 3rd beat of a len=8 TLP → all outputs at reset values next cycle, tag=0.
  - 256 back-to-back TLPs → tag wraps to 0.
